// File: rtl/multiplier_datapath_taint_track_word_if.sv
// Purpose : control-to-datapath bus of the shift-add multiplier, with one taint bit per signal.
// Ports   : master = control FSM side (drives enables/operands, reads multiplierReg/product),
//           slave  = datapath side (the reverse).
interface multiplier_datapath_taint_track_word_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   multiplicand;
  logic               multiplicand_t;
  logic [WIDTH-1:0]   multiplier;
  logic               multiplier_t;
  logic               mdld;
  logic               mdld_t;
  logic               mrld;
  logic               mrld_t;
  logic               rsclear;
  logic               rsclear_t;
  logic               rsload;
  logic               rsload_t;
  logic               rsshr;
  logic               rsshr_t;
  logic [WIDTH-1:0]   multiplierReg;
  logic               multiplierReg_t;
  logic [2*WIDTH-1:0] product;
  logic               product_t;

  modport master (
    output multiplicand, multiplicand_t, multiplier, multiplier_t,
           mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
           rsload, rsload_t, rsshr, rsshr_t,
    input  multiplierReg, multiplierReg_t, product, product_t
  );

  modport slave (
    input  multiplicand, multiplicand_t, multiplier, multiplier_t,
           mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t,
           rsload, rsload_t, rsshr, rsshr_t,
    output multiplierReg, multiplierReg_t, product, product_t
  );
endinterface

// File: rtl/multiplier_datapath_taint_track_word.sv
// Purpose : datapath half of a sequential shift-add multiplier with word-level taint tracking.
//           Holds multiplicand, multiplier and a 2*WIDTH+1 bit result shift register.
// Ports   : clk, rst (async active-low), bus (slave modport): operands, control enables and
//           their taints in; multiplierReg/product and their taints out, all straight from flops.
module multiplier_datapath_taint_track_word #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  multiplier_datapath_taint_track_word_if.slave bus
);

  logic [WIDTH-1:0] r_md;
  logic [WIDTH-1:0] r_mr;
  logic [2*WIDTH:0] r_rs;
  logic             r_md_t;
  logic             r_mr_t;
  logic             r_rs_t;

  // Upper-half accumulate; bit 2W is always 0 after a shift, so WIDTH+1 bits never overflow.
  logic [WIDTH:0]   w_rs_hi_sum;
  assign w_rs_hi_sum = r_rs[2*WIDTH:WIDTH] + {1'b0, r_md};

  // Operand registers. A tainted enable taints the register whether or not it fired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_md   <= '0;
      r_mr   <= '0;
      r_md_t <= 1'b0;
      r_mr_t <= 1'b0;
    end else begin
      if (bus.mdld) r_md <= bus.multiplicand;
      if (bus.mrld) r_mr <= bus.multiplier;
      r_md_t <= bus.mdld_t | (bus.mdld ? bus.multiplicand_t : r_md_t);
      r_mr_t <= bus.mrld_t | (bus.mrld ? bus.multiplier_t   : r_mr_t);
    end
  end

  // Result register: clear beats load beats shift. The add reads the pre-edge r_md, so a
  // concurrent mdld only affects later loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs   <= '0;
      r_rs_t <= 1'b0;
    end else begin
      if (bus.rsclear) begin
        r_rs <= '0;
      end else if (bus.rsload) begin
        r_rs[2*WIDTH:WIDTH] <= w_rs_hi_sum;
      end else if (bus.rsshr) begin
        r_rs <= {1'b0, r_rs[2*WIDTH:1]};
      end
      // An untainted clear with no tainted enables is the only way rs taint drops to 0.
      r_rs_t <= bus.rsclear_t | bus.rsload_t | bus.rsshr_t |
                (bus.rsclear ? 1'b0 : (r_rs_t | (bus.rsload & r_md_t)));
    end
  end

  assign bus.multiplierReg   = r_mr;
  assign bus.multiplierReg_t = r_mr_t;
  assign bus.product         = r_rs[2*WIDTH-1:0];
  assign bus.product_t       = r_rs_t;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_word.sv
// Purpose : self-checking bench for multiplier_datapath_taint_track_word (WIDTH=4).
// Ports   : none; drives the datapath through the master side of the bus interface and
//           compares outputs against a queue of expected values.
module tb_multiplier_datapath_taint_track_word;

  localparam int W = 4;

  // Control enable encoding for the ctl task: {mdld, mrld, rsclear, rsload, rsshr}
  localparam logic [4:0] MDLD = 5'b10000;
  localparam logic [4:0] MRLD = 5'b01000;
  localparam logic [4:0] CLR  = 5'b00100;
  localparam logic [4:0] LD   = 5'b00010;
  localparam logic [4:0] SHR  = 5'b00001;
  localparam logic [4:0] NONE = 5'b00000;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           pt;
    logic [W-1:0]   mr;
    logic           mt;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];

  multiplier_datapath_taint_track_word_if #(.WIDTH(W)) bus ();

  multiplier_datapath_taint_track_word #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2*W-1:0] prod, input logic pt,
                          input logic [W-1:0] mr, input logic mt);
    exp_t e;
    e.prod = prod;
    e.pt   = pt;
    e.mr   = mr;
    e.mt   = mt;
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".product"},         32'(bus.product),         32'(e.prod));
      chk({tag, ".product_t"},       32'(bus.product_t),       32'(e.pt));
      chk({tag, ".multiplierReg"},   32'(bus.multiplierReg),   32'(e.mr));
      chk({tag, ".multiplierReg_t"}, 32'(bus.multiplierReg_t), 32'(e.mt));
    end
  endtask

  // Inputs change at posedge+1, outputs are examined at posedge+1 after the tick.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic [4:0] en, input logic [4:0] en_t);
    {bus.mdld,   bus.mrld,   bus.rsclear,   bus.rsload,   bus.rsshr}   = en;
    {bus.mdld_t, bus.mrld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t} = en_t;
    tick();
    {bus.mdld,   bus.mrld,   bus.rsclear,   bus.rsload,   bus.rsshr}   = NONE;
    {bus.mdld_t, bus.mrld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t} = NONE;
  endtask

  task automatic load_ops(input logic [W-1:0] a, input logic at,
                          input logic [W-1:0] b, input logic bt);
    bus.multiplicand   = a;
    bus.multiplicand_t = at;
    bus.multiplier     = b;
    bus.multiplier_t   = bt;
    ctl(MDLD | MRLD, NONE);
    bus.multiplicand_t = 1'b0;
    bus.multiplier_t   = 1'b0;
  endtask

  task automatic run_mult(input string tag, input logic [W-1:0] a, input logic at,
                          input logic [W-1:0] b, input logic bt);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    push_exp(p, at & (b != '0), b, bt);
    load_ops(a, at, b, bt);
    ctl(CLR, NONE);
    ctl(SHR, NONE);
    for (int i = 0; i < W; i++) begin
      if (b[i]) ctl(LD, NONE);
      ctl(SHR, NONE);
    end
    check_out(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    bus.multiplicand   = '0;
    bus.multiplicand_t = 1'b0;
    bus.multiplier     = '0;
    bus.multiplier_t   = 1'b0;
    {bus.mdld,   bus.mrld,   bus.rsclear,   bus.rsload,   bus.rsshr}   = NONE;
    {bus.mdld_t, bus.mrld_t, bus.rsclear_t, bus.rsload_t, bus.rsshr_t} = NONE;

    tick();
    tick();
    push_exp(8'h00, 1'b0, 4'h0, 1'b0);
    check_out("reset");
    rst = 1'b1;
    tick();

    // Plain multiplies
    run_mult("mul_13x11", 4'd13, 1'b0, 4'd11, 1'b0);
    run_mult("mul_15x15", 4'd15, 1'b0, 4'd15, 1'b0);
    run_mult("mul_0x9",   4'd0,  1'b0, 4'd9,  1'b0);

    // Tainted multiplicand: taint appears only at the first rsload.
    load_ops(4'd13, 1'b1, 4'd11, 1'b0);
    ctl(CLR, NONE);
    push_exp(8'h00, 1'b0, 4'hB, 1'b0);
    check_out("taint_after_clr");
    ctl(SHR, NONE);
    push_exp(8'h00, 1'b0, 4'hB, 1'b0);
    check_out("taint_after_shr");
    ctl(LD, NONE);
    push_exp(8'hD0, 1'b1, 4'hB, 1'b0);
    check_out("taint_first_load");
    ctl(SHR, NONE);                 // bit 0 done
    ctl(LD, NONE);  ctl(SHR, NONE); // bit 1
    ctl(SHR, NONE);                 // bit 2
    ctl(LD, NONE);  ctl(SHR, NONE); // bit 3
    push_exp(8'd143, 1'b1, 4'hB, 1'b0);
    check_out("taint_final");
    ctl(CLR, NONE);
    push_exp(8'h00, 1'b0, 4'hB, 1'b0);
    check_out("taint_kill_clr");

    // Tainted but inactive rsload: value held, taint set and sticky.
    run_mult("mul_13x11_b", 4'd13, 1'b0, 4'd11, 1'b0);
    ctl(NONE, LD);
    push_exp(8'd143, 1'b1, 4'hB, 1'b0);
    check_out("rsload_t_only");
    tick();
    push_exp(8'd143, 1'b1, 4'hB, 1'b0);
    check_out("rsload_t_held");

    // Clear and load together on a nonzero result: clear wins, taint killed.
    ctl(CLR | LD, NONE);
    push_exp(8'h00, 1'b0, 4'hB, 1'b0);
    check_out("clr_and_load");

    // Tainted inactive mrld, then a clean reload.
    ctl(NONE, MRLD);
    push_exp(8'h00, 1'b0, 4'hB, 1'b1);
    check_out("mrld_t_only");
    bus.multiplier = 4'd11;
    ctl(MRLD, NONE);
    push_exp(8'h00, 1'b0, 4'hB, 1'b0);
    check_out("mrld_clean");

    // mdld concurrent with rsload: the add sees the old multiplicand.
    bus.multiplicand = 4'd3;
    ctl(MDLD, NONE);
    bus.multiplicand = 4'd5;
    ctl(MDLD | LD, NONE);
    push_exp(8'h30, 1'b0, 4'hB, 1'b0);
    check_out("load_old_md");
    ctl(LD, NONE);
    push_exp(8'h80, 1'b0, 4'hB, 1'b0);
    check_out("load_new_md");

    // Asynchronous reset mid-multiply, checked before any clock edge.
    load_ops(4'd13, 1'b1, 4'd11, 1'b1);
    ctl(CLR, NONE);
    ctl(SHR, NONE);
    ctl(LD, NONE);
    rst = 1'b0;
    #1;
    push_exp(8'h00, 1'b0, 4'h0, 1'b0);
    check_out("async_reset");
    tick();
    rst = 1'b1;
    tick();
    run_mult("mul_after_reset", 4'd13, 1'b0, 4'd11, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
